approx_mult_err_monitor: RTL and testbench
==========================================

Name: approx_mult_err_monitor

Overview:
- Hardware error-statistics stage that sits directly downstream of the 4x4 approximate multiplier (karthik_reddy).
- Takes the operand pair and the approximate product, and recomputes the exact product internally.
- Computes per-sample integer relative error in percent, using a sequential restoring divider.
- Accumulates running statistics, so the whole 256-pair sweep can be characterised on silicon or FPGA without a simulator.

Parameters:
- ACC_W, 32, width of total_rel_err accumulator; saturating.
- CNT_W, 16, width of sample_count, nonzero_count and err_count; saturating.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous active-high reset.
- clear  in  1  synchronous statistics clear; aborts any in-flight sample.
- in_valid  in  1  a, b and approx are valid.
- in_ready  out  1  high only in IDLE.
- a  in  4  multiplicand fed to the multiplier.
- b  in  4  multiplier operand fed to the multiplier.
- approx  in  8  approximate product from the multiplier.
- sample_valid  out  1  one-cycle pulse; per-sample outputs are valid.
- rel_err  out  15  per-sample floor(|approx-exact|*100/exact); 0 when exact==0.
- abs_err  out  8  per-sample |approx-exact|.
- sample_count  out  CNT_W  accepted samples completed.
- nonzero_count  out  CNT_W  completed samples with exact!=0.
- err_count  out  CNT_W  completed samples with approx!=exact.
- total_rel_err  out  ACC_W  sum of rel_err.
- max_abs_err  out  8  largest abs_err since clear/reset.
- busy  out  1  FSM not in IDLE.

Behaviour:
- Reset (rst=1 at a clk edge): FSM goes to IDLE. All outputs and counters go to 0, in_ready=1, busy=0. Internal datapath registers are zeroed. rst overrides every other input.
- clear (rst=0): same effect as reset on the FSM, counters, accumulators, max_abs_err, rel_err and abs_err. Any in-flight sample is discarded with no sample_valid pulse.
- Handshake:
  - A sample is accepted at an edge where in_valid && in_ready && !clear. a, b and approx are captured at that edge.
  - in_valid while in_ready=0 is ignored. Inputs need not be held.
- FSM states:
  - IDLE: on accept -> CALC.
  - CALC (1 cycle): exact=a*b (8 bit, exact). abs_err=|approx-exact|. Numerator N=abs_err*100 (15 bit). If exact==0 -> ACC with rel_err=0. Otherwise load the divider -> DIV.
  - DIV (exactly 15 cycles): restoring division, one quotient bit per cycle, MSB first. Dividend is N, divisor is zero-extended exact. Quotient is truncated; remainder is discarded. Then -> ACC.
  - ACC (1 cycle): sample_valid=1. rel_err and abs_err are valid and are held until the next ACC or clear. At the edge leaving ACC:
    - sample_count += 1
    - nonzero_count += (exact!=0)
    - err_count += (abs_err!=0)
    - total_rel_err += rel_err
    - max_abs_err = max(max_abs_err, abs_err)
    - then -> IDLE.
- Latency, counting accept edge as cycle 0:
  - exact!=0: sample_valid in cycle 17; next accept possible at the edge ending cycle 18; throughput 1 per 18 cycles.
  - exact==0: sample_valid in cycle 2.
- Saturation:
  - Counters and total_rel_err saturate at all-ones and never wrap.
  - At saturation the other statistics keep updating.
- Simultaneous events:
  - clear in the same cycle as in_valid: the sample is not accepted.
  - clear in ACC: no statistics update; clear wins.
- Arithmetic is unsigned throughout. Maximum rel_err is 25400 (exact=1, approx=255), which fits in 15 bits.
- Mean relative error is not computed in hardware. Software computes total_rel_err / sample_count.

Test Plan:
- Reset, then a=3, b=5, approx=15 -> sample_valid in cycle 17 with rel_err=0, abs_err=0; afterwards sample_count=1, nonzero_count=1, err_count=0.
- a=3, b=5, approx=13 -> rel_err=13 (200/15 truncated), abs_err=2. Then a=1, b=1, approx=2 -> rel_err=100. Afterwards total_rel_err=113, err_count=2, max_abs_err=2.
- a=0, b=9, approx=4 -> sample_valid in cycle 2, rel_err=0, abs_err=4. nonzero_count is unchanged; err_count+1; max_abs_err=4.
- Sequence:
  - Hold in_valid=1 with changing inputs during a sample -> in_ready=0 for cycles 1-17 and no extra samples are counted.
  - Pulse clear at DIV cycle 5 -> no sample_valid, all statistics 0, in_ready=1 the next cycle.
- Full sweep: a,b over 0..15 x 0..15 with approx=a*b -> sample_count=256, nonzero_count=225, err_count=0, total_rel_err=0.
- ACC_W=8: repeated a=1, b=1, approx=2 -> total_rel_err goes 100, 200, 255, 255 (saturates, no wrap) while sample_count keeps incrementing.

Source files
------------

// File: rtl/approx_mult_err_monitor_if.sv
// approx_mult_err_monitor_if: sample handshake (clear/in_valid/in_ready/a/b/approx) plus per-sample and running-statistics outputs
interface approx_mult_err_monitor_if #(
  parameter int ACC_W = 32,
  parameter int CNT_W = 16
);
  logic clear;
  logic in_valid;
  logic in_ready;
  logic [3:0] a;
  logic [3:0] b;
  logic [7:0] approx;
  logic sample_valid;
  logic [14:0] rel_err;
  logic [7:0] abs_err;
  logic [CNT_W-1:0] sample_count;
  logic [CNT_W-1:0] nonzero_count;
  logic [CNT_W-1:0] err_count;
  logic [ACC_W-1:0] total_rel_err;
  logic [7:0] max_abs_err;
  logic busy;
  modport master (
    output clear, in_valid, a, b, approx,
    input in_ready, sample_valid, rel_err, abs_err, sample_count, nonzero_count, err_count, total_rel_err, max_abs_err, busy
  );
  modport slave (
    input clear, in_valid, a, b, approx,
    output in_ready, sample_valid, rel_err, abs_err, sample_count, nonzero_count, err_count, total_rel_err, max_abs_err, busy
  );
endinterface

// File: rtl/approx_mult_err_monitor.sv
// approx_mult_err_monitor: per-sample |approx-a*b| and percent error via 15-cycle restoring divider, with saturating running statistics; ports clk, rst, bus (slave)
module approx_mult_err_monitor #(
  parameter int ACC_W = 32,
  parameter int CNT_W = 16
) (
  input logic clk,
  input logic rst,
  approx_mult_err_monitor_if.slave bus
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] DIV = 2'd2;
  localparam logic [1:0] ACC = 2'd3;
  logic [1:0] state_q, state_d;
  logic [3:0] a_q, a_d, b_q, b_d, cnt_q, cnt_d;
  logic [7:0] ap_q, ap_d, exact_q, exact_d, diff_q, diff_d, rem_q, rem_d;
  logic [7:0] abs_err_q, abs_err_d, max_q, max_d;
  logic [14:0] quo_q, quo_d, rel_err_q, rel_err_d;
  logic [CNT_W-1:0] scnt_q, scnt_d, nzcnt_q, nzcnt_d, ecnt_q, ecnt_d;
  logic [ACC_W-1:0] tot_q, tot_d;
  logic [ACC_W+15:0] tot_sum;
  logic [7:0] exact_c, abs_c;
  logic [8:0] trial, sub;
  logic ge, acc;
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c, input logic en);
    return (en && !(&c)) ? c + CNT_W'(1) : c;
  endfunction
  always_comb begin
    acc = state_q == ACC;
    exact_c = {4'd0, a_q} * {4'd0, b_q};
    abs_c = ap_q >= exact_c ? ap_q - exact_c : exact_c - ap_q;
    trial = {rem_q, quo_q[14]};
    sub = trial - {1'b0, exact_q};
    ge = trial >= {1'b0, exact_q};
    tot_sum = (ACC_W+16)'(tot_q) + (ACC_W+16)'(rel_err_q);
    state_d = state_q == IDLE ? (bus.in_valid ? CALC : IDLE)
            : state_q == CALC ? (exact_c == 8'd0 ? ACC : DIV)
            : state_q == DIV ? (cnt_q == 4'd14 ? ACC : DIV) : IDLE;
    a_d = a_q;
    b_d = b_q;
    ap_d = ap_q;
    exact_d = exact_q;
    diff_d = diff_q;
    rem_d = rem_q;
    quo_d = quo_q;
    cnt_d = cnt_q;
    rel_err_d = rel_err_q;
    abs_err_d = abs_err_q;
    if (state_q == IDLE && bus.in_valid) begin
      a_d = bus.a;
      b_d = bus.b;
      ap_d = bus.approx;
    end
    if (state_q == CALC) begin
      exact_d = exact_c;
      diff_d = abs_c;
      rem_d = '0;
      quo_d = 15'(abs_c) * 15'd100;
      cnt_d = '0;
      if (exact_c == 8'd0) begin
        rel_err_d = '0;
        abs_err_d = abs_c;
      end
    end
    if (state_q == DIV) begin
      rem_d = ge ? sub[7:0] : trial[7:0];
      quo_d = {quo_q[13:0], ge};
      cnt_d = cnt_q + 4'd1;
      if (cnt_q == 4'd14) begin
        rel_err_d = {quo_q[13:0], ge};
        abs_err_d = diff_q;
      end
    end
    scnt_d = sat_inc(scnt_q, acc);
    nzcnt_d = sat_inc(nzcnt_q, acc && exact_q != 8'd0);
    ecnt_d = sat_inc(ecnt_q, acc && abs_err_q != 8'd0);
    tot_d = !acc ? tot_q : (|tot_sum[ACC_W+15:ACC_W]) ? '1 : tot_sum[ACC_W-1:0];
    max_d = (acc && abs_err_q > max_q) ? abs_err_q : max_q;
  end
  always_ff @(posedge clk) begin
    if (rst || bus.clear) begin
      state_q <= IDLE;
      a_q <= '0;
      b_q <= '0;
      ap_q <= '0;
      exact_q <= '0;
      diff_q <= '0;
      rem_q <= '0;
      quo_q <= '0;
      cnt_q <= '0;
      rel_err_q <= '0;
      abs_err_q <= '0;
      scnt_q <= '0;
      nzcnt_q <= '0;
      ecnt_q <= '0;
      tot_q <= '0;
      max_q <= '0;
    end else begin
      state_q <= state_d;
      a_q <= a_d;
      b_q <= b_d;
      ap_q <= ap_d;
      exact_q <= exact_d;
      diff_q <= diff_d;
      rem_q <= rem_d;
      quo_q <= quo_d;
      cnt_q <= cnt_d;
      rel_err_q <= rel_err_d;
      abs_err_q <= abs_err_d;
      scnt_q <= scnt_d;
      nzcnt_q <= nzcnt_d;
      ecnt_q <= ecnt_d;
      tot_q <= tot_d;
      max_q <= max_d;
    end
  end
  assign bus.in_ready = state_q == IDLE;
  assign bus.busy = state_q != IDLE;
  assign bus.sample_valid = acc && !bus.clear;
  assign bus.rel_err = rel_err_q;
  assign bus.abs_err = abs_err_q;
  assign bus.sample_count = scnt_q;
  assign bus.nonzero_count = nzcnt_q;
  assign bus.err_count = ecnt_q;
  assign bus.total_rel_err = tot_q;
  assign bus.max_abs_err = max_q;
endmodule

// File: tb/tb_approx_mult_err_monitor.sv
// tb_approx_mult_err_monitor: directed checks of latency, error values, statistics, clear and saturation
module tb_approx_mult_err_monitor;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int total = 0;
  int bad = 0;
  int rdy;
  int svs;
  int k8;
  int e8 [4] = '{100, 200, 255, 255};
  always #5 clk = ~clk;
  approx_mult_err_monitor_if #(.ACC_W(32), .CNT_W(16)) bus ();
  approx_mult_err_monitor_if #(.ACC_W(8), .CNT_W(16)) bus8 ();
  approx_mult_err_monitor #(.ACC_W(32), .CNT_W(16)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
  approx_mult_err_monitor #(.ACC_W(8), .CNT_W(16)) dut8 (.clk(clk), .rst(rst), .bus(bus8.slave));
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  task automatic stats(input string tag, input int sc, input int nz, input int ec, input int tot, input int mx);
    chk({tag, " sample_count"}, 64'(bus.sample_count), 64'(sc));
    chk({tag, " nonzero_count"}, 64'(bus.nonzero_count), 64'(nz));
    chk({tag, " err_count"}, 64'(bus.err_count), 64'(ec));
    chk({tag, " total_rel_err"}, 64'(bus.total_rel_err), 64'(tot));
    chk({tag, " max_abs_err"}, 64'(bus.max_abs_err), 64'(mx));
  endtask
  task automatic run(input string tag, input logic [3:0] ia, input logic [3:0] ib, input logic [7:0] iap,
                     input int lat, input int rel, input int ab);
    int k;
    chk({tag, " in_ready"}, 64'(bus.in_ready), 64'd1);
    bus.in_valid = 1'b1;
    bus.a = ia;
    bus.b = ib;
    bus.approx = iap;
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.a = 4'($urandom);
    bus.b = 4'($urandom);
    bus.approx = 8'($urandom);
    k = 1;
    while (!bus.sample_valid && k < 40) begin
      @(negedge clk);
      k++;
    end
    chk({tag, " latency"}, 64'(k), 64'(lat));
    chk({tag, " rel_err"}, 64'(bus.rel_err), 64'(rel));
    chk({tag, " abs_err"}, 64'(bus.abs_err), 64'(ab));
    @(negedge clk);
  endtask
  initial begin
    bus.clear = 1'b0;
    bus.in_valid = 1'b0;
    bus.a = '0;
    bus.b = '0;
    bus.approx = '0;
    bus8.clear = 1'b0;
    bus8.in_valid = 1'b0;
    bus8.a = '0;
    bus8.b = '0;
    bus8.approx = '0;
    repeat (2) @(negedge clk);
    chk("reset in_ready", 64'(bus.in_ready), 64'd1);
    chk("reset busy", 64'(bus.busy), 64'd0);
    chk("reset sample_valid", 64'(bus.sample_valid), 64'd0);
    chk("reset rel_err", 64'(bus.rel_err), 64'd0);
    chk("reset abs_err", 64'(bus.abs_err), 64'd0);
    stats("reset", 0, 0, 0, 0, 0);
    rst = 1'b0;
    @(negedge clk);
    run("exact15", 4'd3, 4'd5, 8'd15, 17, 0, 0);
    stats("after exact15", 1, 1, 0, 0, 0);
    run("approx13", 4'd3, 4'd5, 8'd13, 17, 13, 2);
    run("one_vs_two", 4'd1, 4'd1, 8'd2, 17, 100, 1);
    stats("after one_vs_two", 3, 3, 2, 113, 2);
    run("zero_exact", 4'd0, 4'd9, 8'd4, 2, 0, 4);
    stats("after zero_exact", 4, 3, 3, 113, 4);
    bus.in_valid = 1'b1;
    bus.a = 4'd2;
    bus.b = 4'd2;
    bus.approx = 8'd5;
    @(negedge clk);
    rdy = 0;
    for (int k = 1; k < 17; k++) begin
      rdy += int'(bus.in_ready);
      bus.a = 4'($urandom);
      bus.b = 4'($urandom);
      bus.approx = 8'($urandom);
      @(negedge clk);
    end
    rdy += int'(bus.in_ready);
    chk("hold sample_valid c17", 64'(bus.sample_valid), 64'd1);
    chk("hold rel_err", 64'(bus.rel_err), 64'd25);
    chk("hold abs_err", 64'(bus.abs_err), 64'd1);
    bus.in_valid = 1'b0;
    chk("hold in_ready highs c1-17", 64'(rdy), 64'd0);
    svs = 0;
    repeat (20) begin
      @(negedge clk);
      svs += int'(bus.sample_valid);
    end
    chk("hold extra samples", 64'(svs), 64'd0);
    stats("after hold", 5, 4, 4, 138, 4);
    bus.in_valid = 1'b1;
    bus.a = 4'd15;
    bus.b = 4'd15;
    bus.approx = 8'd0;
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (5) @(negedge clk);
    chk("pre-clear busy", 64'(bus.busy), 64'd1);
    bus.clear = 1'b1;
    @(negedge clk);
    bus.clear = 1'b0;
    chk("clear in_ready", 64'(bus.in_ready), 64'd1);
    chk("clear rel_err", 64'(bus.rel_err), 64'd0);
    chk("clear abs_err", 64'(bus.abs_err), 64'd0);
    stats("after clear", 0, 0, 0, 0, 0);
    svs = 0;
    repeat (20) begin
      @(negedge clk);
      svs += int'(bus.sample_valid);
    end
    chk("clear discarded sample_valid", 64'(svs), 64'd0);
    bus.in_valid = 1'b1;
    bus.clear = 1'b1;
    bus.a = 4'd7;
    bus.b = 4'd7;
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.clear = 1'b0;
    chk("clear+valid busy", 64'(bus.busy), 64'd0);
    for (int i = 0; i < 16; i++)
      for (int j = 0; j < 16; j++)
        run("sweep", 4'(i), 4'(j), 8'(i * j), (i * j == 0) ? 2 : 17, 0, 0);
    stats("after sweep", 256, 225, 0, 0, 0);
    for (int n = 0; n < 4; n++) begin
      bus8.in_valid = 1'b1;
      bus8.a = 4'd1;
      bus8.b = 4'd1;
      bus8.approx = 8'd2;
      @(negedge clk);
      bus8.in_valid = 1'b0;
      k8 = 1;
      while (!bus8.sample_valid && k8 < 40) begin
        @(negedge clk);
        k8++;
      end
      @(negedge clk);
      chk("sat8 total_rel_err", 64'(bus8.total_rel_err), 64'(e8[n]));
      chk("sat8 sample_count", 64'(bus8.sample_count), 64'(n + 1));
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
